// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RiSC-16 instruction decode / operand fetch stage
//
// Holds the 8x16 register file (r0 hard-wired to zero) and a busy scoreboard
// for r1..r7. The stage decodes one instruction per cycle into an ALU operand
// bundle with a one-cycle latency, and it stalls when a source register still
// waits on a writeback.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   handshake with fetch
//   in_instr, in_pc       instruction word and its address
//   wb_en/addr/data       register-file writeback port (write-through bypass)
//   out_valid / out_ready handshake with the ALU stage
//   op1, op2, alu_op      ALU operands and operation (000 ADD, 001 NAND)
//   out_dest, out_wen     destination register and its write enable
//   out_mem_rd/mem_wr     LW / SW class flags
//   out_is_beq/is_jalr    BEQ / JALR class flags
//   out_aux               SW store data, BEQ offset, or JALR target
// -----------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] op1,
    output logic [15:0] op2,
    output logic [2:0]  alu_op,
    output logic [2:0]  out_dest,
    output logic        out_wen,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_is_beq,
    output logic        out_is_jalr,
    output logic [15:0] out_aux
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_NAND = 3'b001;

    // Sign-extend a 7-bit immediate to 16 bits.
    function automatic logic [15:0] sext7(input logic [6:0] imm);
        logic signed [6:0]  s;
        logic signed [15:0] w;
        s = imm;
        w = 16'(s);
        return w;
    endfunction

    // Two's-complement negate, modulo 2^16.
    function automatic logic [15:0] neg16(input logic [15:0] v);
        return (~v) + 16'd1;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0] regs_q [0:7];
    logic [15:0] regs_d [0:7];
    logic [7:1]  busy_q, busy_d;

    logic        out_valid_q, out_valid_d;
    logic [15:0] op1_q, op1_d;
    logic [15:0] op2_q, op2_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [2:0]  dest_q, dest_d;
    logic        wen_q, wen_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        is_beq_q, is_beq_d;
    logic        is_jalr_q, is_jalr_d;
    logic [15:0] aux_q, aux_d;

    // ------------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------------
    logic [2:0]  opcode, fa, fb, fc;
    logic [15:0] rf_a, rf_b, rf_c;
    logic        wb_wr;
    logic [7:0]  wb_clr_1h, set_1h, busy_eff8;
    logic        use_a, use_b, use_c;
    logic        hazard, transfer;
    logic        wen_class;
    logic [15:0] dec_op1, dec_op2, dec_aux;
    logic [2:0]  dec_alu;
    logic        dec_wen, dec_mem_rd, dec_mem_wr, dec_beq, dec_jalr;

    assign opcode = in_instr[15:13];
    assign fa     = in_instr[12:10];
    assign fb     = in_instr[9:7];
    assign fc     = in_instr[2:0];

    // Writes to r0 are dropped at the port so r0 is never written or cleared.
    assign wb_wr  = wb_en && (wb_addr != 3'd0);

    // Register reads with write-through bypass from the writeback port.
    always_comb begin
        rf_a = 16'h0000;
        rf_b = 16'h0000;
        rf_c = 16'h0000;
        if (fa != 3'd0) rf_a = (wb_wr && wb_addr == fa) ? wb_data : regs_q[fa];
        if (fb != 3'd0) rf_b = (wb_wr && wb_addr == fb) ? wb_data : regs_q[fb];
        if (fc != 3'd0) rf_c = (wb_wr && wb_addr == fc) ? wb_data : regs_q[fc];
    end

    always_comb begin
        dec_op1    = 16'h0000;
        dec_op2    = 16'h0000;
        dec_aux    = 16'h0000;
        dec_alu    = ALU_ADD;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_beq    = 1'b0;
        dec_jalr   = 1'b0;
        wen_class  = 1'b0;
        use_a      = 1'b0;
        use_b      = 1'b0;
        use_c      = 1'b0;
        case (opcode)
            OP_ADD, OP_NAND: begin
                dec_op1   = rf_b;
                dec_op2   = rf_c;
                dec_alu   = (opcode == OP_NAND) ? ALU_NAND : ALU_ADD;
                wen_class = 1'b1;
                use_b     = 1'b1;
                use_c     = 1'b1;
            end
            OP_ADDI: begin
                dec_op1   = rf_b;
                dec_op2   = sext7(in_instr[6:0]);
                wen_class = 1'b1;
                use_b     = 1'b1;
            end
            OP_LUI: begin
                dec_op2   = {in_instr[9:0], 6'b000000};
                wen_class = 1'b1;
            end
            OP_SW: begin
                dec_op1    = rf_b;
                dec_op2    = sext7(in_instr[6:0]);
                dec_aux    = rf_a;
                dec_mem_wr = 1'b1;
                use_a      = 1'b1;
                use_b      = 1'b1;
            end
            OP_LW: begin
                dec_op1    = rf_b;
                dec_op2    = sext7(in_instr[6:0]);
                dec_mem_rd = 1'b1;
                wen_class  = 1'b1;
                use_b      = 1'b1;
            end
            OP_BEQ: begin
                // op1 + op2 == 0 exactly when R[rA] == R[rB].
                dec_op1 = rf_a;
                dec_op2 = neg16(rf_b);
                dec_aux = sext7(in_instr[6:0]);
                dec_beq = 1'b1;
                use_a   = 1'b1;
                use_b   = 1'b1;
            end
            default: begin // OP_JALR: ALU computes the link value pc+1
                dec_op1   = in_pc;
                dec_op2   = 16'h0001;
                dec_aux   = rf_b;
                dec_jalr  = 1'b1;
                wen_class = 1'b1;
                use_b     = 1'b1;
            end
        endcase
        dec_wen = wen_class && (fa != 3'd0);
    end

    // ------------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        wb_clr_1h = 8'h00;
        if (wb_wr) wb_clr_1h[wb_addr] = 1'b1;
    end

    // A writeback landing this cycle already releases its register for the
    // hazard check, matching the bypassed read data.
    assign busy_eff8 = {busy_q & ~wb_clr_1h[7:1], 1'b0};

    assign hazard = (use_a && busy_eff8[fa]) ||
                    (use_b && busy_eff8[fb]) ||
                    (use_c && busy_eff8[fc]);

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign transfer = in_valid && in_ready;

    always_comb begin
        set_1h = 8'h00;
        if (transfer && dec_wen) set_1h[fa] = 1'b1;
    end

    // Set after clear: a same-cycle clear and set leaves the register busy.
    assign busy_d = (busy_q & ~wb_clr_1h[7:1]) | set_1h[7:1];

    always_comb begin
        for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
        if (wb_wr) regs_d[wb_addr] = wb_data;
    end

    // ------------------------------------------------------------------------
    // Output bundle register
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_op_d    = alu_op_q;
        dest_d      = dest_q;
        wen_d       = wen_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        is_beq_d    = is_beq_q;
        is_jalr_d   = is_jalr_q;
        aux_d       = aux_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            op1_d       = dec_op1;
            op2_d       = dec_op2;
            alu_op_d    = dec_alu;
            dest_d      = fa;
            wen_d       = dec_wen;
            mem_rd_d    = dec_mem_rd;
            mem_wr_d    = dec_mem_wr;
            is_beq_d    = dec_beq;
            is_jalr_d   = dec_jalr;
            aux_d       = dec_aux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= 16'h0000;
            op2_q       <= 16'h0000;
            alu_op_q    <= 3'b000;
            dest_q      <= 3'b000;
            wen_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            is_beq_q    <= 1'b0;
            is_jalr_q   <= 1'b0;
            aux_q       <= 16'h0000;
        end else begin
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_op_q    <= alu_op_d;
            dest_q      <= dest_d;
            wen_q       <= wen_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            is_beq_q    <= is_beq_d;
            is_jalr_q   <= is_jalr_d;
            aux_q       <= aux_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign alu_op      = alu_op_q;
    assign out_dest    = dest_q;
    assign out_wen     = wen_q;
    assign out_mem_rd  = mem_rd_q;
    assign out_mem_wr  = mem_wr_q;
    assign out_is_beq  = is_beq_q;
    assign out_is_jalr = is_jalr_q;
    assign out_aux     = aux_q;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed testbench for id_stage
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op1, op2;
    logic [2:0]  alu_op;
    logic [2:0]  out_dest;
    logic        out_wen, out_mem_rd, out_mem_wr, out_is_beq, out_is_jalr;
    logic [15:0] out_aux;

    int errors = 0;
    int checks = 0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op),
        .out_dest(out_dest), .out_wen(out_wen),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_is_beq(out_is_beq), .out_is_jalr(out_is_jalr),
        .out_aux(out_aux)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction

    // Drive helpers: every task starts and ends 1 time unit after a rising edge.
    task automatic do_wb(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
        in_instr = ins; in_pc = pc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0; out_ready = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0 || out_aux !== 16'h0) begin errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", op1, op2, out_aux); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add;
        do_wb(3'd1, 16'h0005);
        do_wb(3'd2, 16'h0003);
        issue(rrr(3'b000, 3'd3, 3'd1, 3'd2), 16'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (op1 !== 16'h0005 || op2 !== 16'h0003) begin errors++; $display("FAIL add_ops got=%h,%h exp=0005,0003", op1, op2); end
        checks++; if (alu_op !== 3'b000 || out_dest !== 3'd3 || out_wen !== 1'b1) begin errors++; $display("FAIL add_ctl got=%b/%0d/%b exp=000/3/1", alu_op, out_dest, out_wen); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_clear got=%b exp=0", out_valid); end
    endtask

    task automatic test_nand_hazard;
        do_wb(3'd4, 16'hFFFF);
        do_wb(3'd5, 16'h00FF);
        issue(rrr(3'b010, 3'd6, 3'd4, 3'd5), 16'h0);
        checks++; if (op1 !== 16'hFFFF || op2 !== 16'h00FF || alu_op !== 3'b001) begin errors++; $display("FAIL nand_ops got=%h,%h,%b exp=FFFF,00FF,001", op1, op2, alu_op); end
        in_instr = rrr(3'b000, 3'd7, 3'd6, 3'd1); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_stall1 got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL haz_stall2 got=rdy%b vld%b exp=0,0", in_ready, out_valid); end
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL haz_wb_release got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op1 !== 16'h1234 || op2 !== 16'h0005 || out_dest !== 3'd7) begin errors++; $display("FAIL haz_issue got=%b %h %h %0d exp=1 1234 0005 7", out_valid, op1, op2, out_dest); end
    endtask

    task automatic test_bypass;
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0042;
        in_instr = rri(3'b001, 3'd2, 3'd1, 7'h7F); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (op1 !== 16'h0042 || op2 !== 16'hFFFF || out_dest !== 3'd2 || out_wen !== 1'b1) begin errors++; $display("FAIL byp_ops got=%h %h %0d %b exp=0042 FFFF 2 1", op1, op2, out_dest, out_wen); end
    endtask

    task automatic test_lui_r0;
        issue({3'b011, 3'd1, 10'h3FF}, 16'h0);
        checks++; if (op1 !== 16'h0000 || op2 !== 16'hFFC0 || out_wen !== 1'b1) begin errors++; $display("FAIL lui got=%h %h %b exp=0000 FFC0 1", op1, op2, out_wen); end
        do_wb(3'd1, 16'h0007);
        issue(rrr(3'b000, 3'd0, 3'd1, 3'd1), 16'h0);
        checks++; if (op1 !== 16'h0007 || op2 !== 16'h0007 || out_wen !== 1'b0 || out_dest !== 3'd0) begin errors++; $display("FAIL add_r0 got=%h %h %b %0d exp=0007 0007 0 0", op1, op2, out_wen, out_dest); end
    endtask

    task automatic test_backpressure_beq;
        do_wb(3'd2, 16'h0007);
        out_ready = 1'b0;
        issue(rri(3'b110, 3'd1, 3'd2, 7'h7D), 16'h0);
        checks++; if (op1 !== 16'h0007 || op2 !== 16'hFFF9 || out_aux !== 16'hFFFD) begin errors++; $display("FAIL beq got=%h %h %h exp=0007 FFF9 FFFD", op1, op2, out_aux); end
        checks++; if (out_is_beq !== 1'b1 || out_wen !== 1'b0) begin errors++; $display("FAIL beq_flags got=beq%b wen%b exp=1,0", out_is_beq, out_wen); end
        checks++; if (16'(op1 + op2) !== 16'h0000) begin errors++; $display("FAIL beq_sum got=%h exp=0000", 16'(op1 + op2)); end
        in_instr = rri(3'b001, 3'd5, 3'd0, 7'h05); in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || op2 !== 16'hFFF9 || op1 !== 16'h0007) begin errors++; $display("FAIL hold%0d got=rdy%b vld%b %h %h exp=0 1 0007 FFF9", k, in_ready, out_valid, op1, op2); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (op1 !== 16'h0000 || op2 !== 16'h0005 || out_dest !== 3'd5 || out_is_beq !== 1'b0) begin errors++; $display("FAIL after_hold got=%h %h %0d %b exp=0000 0005 5 0", op1, op2, out_dest, out_is_beq); end
    endtask

    task automatic test_mem_jalr;
        issue(rri(3'b100, 3'd4, 3'd1, 7'h02), 16'h0);
        checks++; if (op1 !== 16'h0007 || op2 !== 16'h0002 || out_aux !== 16'hFFFF || out_mem_wr !== 1'b1 || out_wen !== 1'b0) begin errors++; $display("FAIL sw got=%h %h %h wr%b wen%b exp=0007 0002 FFFF 1 0", op1, op2, out_aux, out_mem_wr, out_wen); end
        issue(rri(3'b101, 3'd6, 3'd1, 7'h7F), 16'h0);
        checks++; if (op1 !== 16'h0007 || op2 !== 16'hFFFF || out_mem_rd !== 1'b1 || out_mem_wr !== 1'b0 || out_wen !== 1'b1 || out_dest !== 3'd6) begin errors++; $display("FAIL lw got=%h %h rd%b wr%b wen%b %0d exp=0007 FFFF 1 0 1 6", op1, op2, out_mem_rd, out_mem_wr, out_wen, out_dest); end
        issue(rri(3'b111, 3'd7, 3'd4, 7'h00), 16'h0100);
        checks++; if (op1 !== 16'h0100 || op2 !== 16'h0001 || out_aux !== 16'hFFFF || out_is_jalr !== 1'b1 || out_wen !== 1'b1 || out_dest !== 3'd7) begin errors++; $display("FAIL jalr got=%h %h %h j%b wen%b %0d exp=0100 0001 FFFF 1 1 7", op1, op2, out_aux, out_is_jalr, out_wen, out_dest); end
    endtask

    task automatic test_reset_mid;
        // r3 is still busy from test_add; out_valid holds the JALR bundle.
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", out_valid); end
        in_instr = rrr(3'b000, 3'd0, 3'd3, 3'd3); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_busy got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || op1 !== 16'h0 || out_aux !== 16'h0 || out_is_jalr !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL async_rst got=%b %h %h %b %b exp=0", out_valid, op1, out_aux, out_is_jalr, out_wen); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || op1 !== 16'h0 || op2 !== 16'h0) begin errors++; $display("FAIL post_rst_r3 got=%b %h %h exp=1 0 0", out_valid, op1, op2); end
        out_ready = 1'b1;
        in_instr = rrr(3'b000, 3'd0, 3'd6, 3'd7);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_sb got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0) begin errors++; $display("FAIL post_rst_r67 got=%h %h exp=0 0", op1, op2); end
        issue(rrr(3'b000, 3'd0, 3'd1, 3'd2), 16'h0);
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0) begin errors++; $display("FAIL post_rst_r12 got=%h %h exp=0 0", op1, op2); end
        issue(rrr(3'b000, 3'd0, 3'd4, 3'd5), 16'h0);
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0) begin errors++; $display("FAIL post_rst_r45 got=%h %h exp=0 0", op1, op2); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_nand_hazard();
        test_bypass();
        test_lui_r0();
        test_backpressure_beq();
        test_mem_jalr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits, register file at 8 entries.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_instr  input  16  RiSC-16 instruction: opcode [15:13], rA [12:10], rB [9:7], rC [2:0], imm7 [6:0], imm10 [9:0].
REQ-008 in_pc  input  16  instruction address.
REQ-009 wb_en, wb_addr, wb_data  input  1/3/16  writeback port into the register file.
REQ-010 out_valid  output  1  decoded operands valid toward the ALU stage.
REQ-011 out_ready  input  1  downstream accepts the decoded bundle.
REQ-012 op1, op2  output  16  ALU operands.
REQ-013 alu_op  output  3  000 ADD, 001 NAND; other codes never driven.
REQ-014 out_dest, out_wen  output  3/1  destination register and write enable.
REQ-015 out_mem_rd, out_mem_wr, out_is_beq, out_is_jalr  output  1 each  instruction class flags.
REQ-016 out_aux  output  16  SW store data, BEQ sign-extended imm7, or JALR jump target.

Function
REQ-017 The block SHALL hold an 8x16 register file; r0 SHALL read 0 and writes to r0 SHALL be ignored.
REQ-018 A transfer SHALL occur when in_valid && in_ready; the decoded bundle SHALL appear on outputs the next cycle (latency 1).
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !hazard, and SHALL NOT depend on in_ready of any downstream combinational path other than out_ready.
REQ-020 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-021 out_valid SHALL clear after a handshake with no new transfer.
REQ-022 Decode: ADD op1=R[rB] op2=R[rC] ADD; NAND same with NAND; ADDI op1=R[rB] op2=sext(imm7) ADD; LUI op1=0 op2={imm10,6'b0} ADD.
REQ-023 Decode: LW op1=R[rB] op2=sext(imm7) ADD mem_rd; SW same with mem_wr, out_aux=R[rA], out_wen=0.
REQ-024 Decode: BEQ op1=R[rA] op2=(~R[rB])+1 mod 2^16 ADD, out_aux=sext(imm7), out_wen=0 (result 0 means equal).
REQ-025 Decode: JALR op1=in_pc op2=1 ADD, out_aux=R[rB], dest rA.
REQ-026 out_dest SHALL be rA; out_wen SHALL be 1 for ADD/ADDI/NAND/LUI/LW/JALR with rA!=0, else 0.
REQ-027 A 7-bit scoreboard SHALL mark r1..r7 busy; a transfer with out_wen=1 SHALL set busy[rA].
REQ-028 wb_en with wb_addr!=0 SHALL write R[wb_addr] and clear busy[wb_addr].
REQ-029 Simultaneous clear and set of the same register SHALL leave it busy.
REQ-030 hazard SHALL be 1 when any source register used by in_instr (per REQ-022..025) is busy; r0 is never busy.
REQ-031 A register read in the same cycle as a writeback to it SHALL return wb_data (write-through bypass), and that writeback's clear SHALL count in the hazard check.
REQ-032 Arithmetic SHALL be modulo 2^16; no overflow flags.

Reset
REQ-033 On rst_n low, all R[i], scoreboard, out_valid and all output data/flags SHALL go to 0 immediately, independent of clk.
REQ-034 Reset asserted mid-transfer SHALL discard the in-flight bundle; in_ready SHALL be 1 in the first cycle after deassertion when out_ready is don't-care.

Verification
REQ-035 Reset, wb r1=5, r2=3; ADD r3,r1,r2 -> next cycle op1=5 op2=3 alu_op=000 out_dest=3 out_wen=1.
REQ-036 wb r4=FFFF, r5=00FF; NAND r6,r4,r5 -> op1=FFFF op2=00FF alu_op=001; next ADD r7,r6,r1 stalls (in_ready=0) until wb r6, then issues.
REQ-037 wb r1 in same cycle as ADDI r2,r1,-1 presented -> no stall, op1=wb_data, op2=FFFF.
REQ-038 LUI r1,0x3FF -> op1=0 op2=FFC0; ADD r0,r1,r1 -> out_wen=0, no busy set.
REQ-039 out_ready held 0 three cycles -> outputs stable, in_ready=0; BEQ r1,r2 with r1=r2=7 -> op2=FFF9, op1+op2=0.
REQ-040 rst_n pulsed low with out_valid=1 and r3 busy -> out_valid=0, scoreboard clear, R[1..7]=0.
